// File: rtl/branch_target_unit_pkg.sv
// Shared definitions for the branch target unit: addressing-mode encoding and
// the control payload carried alongside each pipeline stage.
package branch_target_unit_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PCREL  = 2'b01,
        MODE_REG    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  taken;
    } s1_ctrl_t;

    typedef struct packed {
        logic redirect;
        logic err;
    } s2_flags_t;

endpackage

// File: rtl/branch_target_unit_sext.sv
// Parameterised sign extension from IN_W to OUT_W bits (OUT_W >= IN_W).
module sext_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] extended
);

    assign extended = OUT_W'($signed(value));

endmodule

// File: rtl/branch_target_unit.sv
// Two-stage branch target computation with valid/ready flow control and a
// saturating redirect counter. Optional alignment fault check: BTU_ALIGN_CHECK_EN.
module branch_target_unit
    import branch_target_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIRECT_W = 26,
    parameter int PCREL_W  = 21,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic                taken,
    input  logic [XLEN-1:0]     pc,
    input  logic [DIRECT_W-1:0] label,
    input  logic [XLEN-1:0]     rs_val,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     target,
    output logic                redirect,
    output logic                err,
    output logic [CNT_W-1:0]    redirect_cnt
);

    logic [XLEN-1:0]  ext_direct_s;
    logic [XLEN-1:0]  ext_pcrel_s;
    logic [XLEN-1:0]  ext_s;
    logic             s1_valid_r;
    logic [XLEN-1:0]  s1_ext_r;
    logic [XLEN-1:0]  s1_pc_r;
    s1_ctrl_t         s1_ctrl_r;
    logic             s1_advance_s;
    logic [XLEN-1:0]  tgt_s;
    logic             rsvd_s;
    logic             err_s;
    logic             s2_valid_r;
    logic [XLEN-1:0]  target_r;
    s2_flags_t        flags_r;
    logic [CNT_W-1:0] cnt_r;
    logic             xfer_s;

    sext_param #(.IN_W(DIRECT_W), .OUT_W(XLEN)) u_sext_direct (
        .value    (label),
        .extended (ext_direct_s)
    );

    sext_param #(.IN_W(PCREL_W), .OUT_W(XLEN)) u_sext_pcrel (
        .value    (label[PCREL_W-1:0]),
        .extended (ext_pcrel_s)
    );

    assign xfer_s       = s2_valid_r & out_ready;
    assign s1_advance_s = s1_valid_r & (~s2_valid_r | out_ready);
    assign in_ready     = ~s1_valid_r | s1_advance_s;

    // Stage-1 immediate selection; register mode forwards the operand unchanged.
    always_comb begin
        ext_s = '0;
        case (mode)
            MODE_DIRECT: ext_s = ext_direct_s;
            MODE_PCREL:  ext_s = ext_pcrel_s;
            MODE_REG:    ext_s = rs_val;
            MODE_RSVD:   ext_s = '0;
            default:     ext_s = '0;
        endcase
    end

    // Stage-2 target arithmetic; PC-relative addition wraps silently.
    always_comb begin
        tgt_s  = '0;
        rsvd_s = 1'b0;
        case (s1_ctrl_r.mode)
            MODE_DIRECT: tgt_s = s1_ext_r;
            MODE_PCREL:  tgt_s = s1_pc_r + s1_ext_r;
            MODE_REG:    tgt_s = s1_ext_r;
            MODE_RSVD:   rsvd_s = 1'b1;
            default:     rsvd_s = 1'b1;
        endcase
    end

`ifdef BTU_ALIGN_CHECK_EN
    assign err_s = rsvd_s | (tgt_s[1:0] != 2'b00);
`else
    assign err_s = rsvd_s;
`endif

    // Stage 1 register: occupancy and captured request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_ext_r   <= '0;
            s1_pc_r    <= '0;
            s1_ctrl_r  <= '0;
        end else begin
            if (flush) begin
                s1_valid_r <= 1'b0;
            end else if (in_ready) begin
                s1_valid_r <= in_valid;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (in_valid && in_ready) begin
                s1_ext_r  <= ext_s;
                s1_pc_r   <= pc;
                s1_ctrl_r <= '{mode: mode_e'(mode), taken: taken};
            end
        end
    end

    // Stage 2 register: result held stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            target_r   <= '0;
            flags_r    <= '0;
        end else begin
            if (flush) begin
                s2_valid_r <= 1'b0;
            end else if (!s2_valid_r || out_ready) begin
                s2_valid_r <= s1_valid_r;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
            if (s1_advance_s) begin
                target_r <= tgt_s;
                flags_r  <= '{redirect: s1_ctrl_r.taken & ~err_s, err: err_s};
            end
        end
    end

    // Delivered-redirect counter; a transfer in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (xfer_s && flags_r.redirect && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_valid    = s2_valid_r;
    assign target       = target_r;
    assign redirect     = flags_r.redirect;
    assign err          = flags_r.err;
    assign redirect_cnt = cnt_r;

endmodule

// File: tb/tb_branch_target_unit.sv
// Randomised and directed bench for branch_target_unit against a queue-based
// reference model of in-flight requests.
module tb_branch_target_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic        taken;
    logic [31:0] pc;
    logic [25:0] label;
    logic [31:0] rs_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] target;
    logic        redirect;
    logic        err;
    logic [3:0]  redirect_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] target;
        logic        redirect;
        logic        err;
        bit          fresh;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_cnt;

    branch_target_unit #(
        .XLEN(32), .DIRECT_W(26), .PCREL_W(21), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .taken(taken), .pc(pc), .label(label), .rs_val(rs_val),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .target(target), .redirect(redirect), .err(err),
        .redirect_cnt(redirect_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [1:0] m, input logic tk, input logic [31:0] p,
                                     input logic [25:0] lb, input logic [31:0] rs);
        exp_t   e;
        longint imm;
        longint sum;
        e.target = 32'h0;
        e.err    = 1'b0;
        e.fresh  = 1'b1;
        imm      = 64'sd0;
        sum      = 64'sd0;
        case (m)
            2'd0: begin
                imm = longint'(lb);
                if (lb[25]) imm = imm - 64'sh400_0000;
                e.target = imm[31:0];
            end
            2'd1: begin
                imm = longint'(lb[20:0]);
                if (lb[20]) imm = imm - 64'sh20_0000;
                sum = longint'(p) + imm;
                e.target = sum[31:0];
            end
            2'd2: e.target = rs;
            default: e.err = 1'b1;
        endcase
`ifdef BTU_ALIGN_CHECK_EN
        if (m != 2'd3 && e.target[1:0] != 2'b00) e.err = 1'b1;
`endif
        e.redirect = tk && !e.err;
        return e;
    endfunction

    // Reference model and per-cycle comparison, sampled on the falling edge.
    initial begin
        bit exp_ov;
        bit exp_ir;
        bit xfer;
        bit acc;
        m_cnt = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
                m_cnt = 4'h0;
            end else begin
                exp_ov = (q.size() > 0) && !q[0].fresh;
                exp_ir = (q.size() < 2) || (out_ready === 1'b1);
                check("out_valid", 64'(out_valid), 64'(exp_ov));
                check("in_ready", 64'(in_ready), 64'(exp_ir));
                check("redirect_cnt", 64'(redirect_cnt), 64'(m_cnt));
                if (exp_ov) begin
                    check("target", 64'(target), 64'(q[0].target));
                    check("redirect", 64'(redirect), 64'(q[0].redirect));
                    check("err", 64'(err), 64'(q[0].err));
                end
                xfer = exp_ov && out_ready;
                acc  = in_valid && exp_ir;
                if (xfer) begin
                    if (q[0].redirect && m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
                    void'(q.pop_front());
                end
                foreach (q[i]) q[i].fresh = 1'b0;
                if (flush) q.delete();
                else if (acc) q.push_back(predict(mode, taken, pc, label, rs_val));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic tk, input logic [31:0] p,
                        input logic [25:0] lb, input logic [31:0] rs);
        bit done;
        int n;
        mode = m; taken = tk; pc = p; label = lb; rs_val = rs;
        in_valid = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_timeout: got out_valid=0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        int lat;
        rst = 1'b0; in_valid = 1'b0; mode = 2'b00; taken = 1'b0; pc = 32'h0;
        label = 26'h0; rs_val = 32'h0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_cnt", 64'(redirect_cnt), 64'h0);
        rst = 1'b1;
        tick();
        check("ready_after_rst", 64'(in_ready), 64'h1);

        // Scenario 1: PC-relative backwards branch
        send(2'b01, 1'b1, 32'h0000_1000, 26'h01F_FFFC, 32'h0);
        wait_out(lat);
        check("s1_latency", 64'(lat), 64'd2);
        check("s1_target", 64'(target), 64'h0000_0FFC);
        check("s1_redirect", 64'(redirect), 64'h1);
        @(negedge clk);
        check("s1_cnt", 64'(redirect_cnt), 64'h1);
        tick();

        // Scenario 2: pseudo-direct negative label, not taken
        send(2'b00, 1'b0, 32'h0, 26'h200_0000, 32'h0);
        wait_out(lat);
        check("s2_target", 64'(target), 64'hFE00_0000);
        check("s2_redirect", 64'(redirect), 64'h0);
        @(negedge clk);
        check("s2_cnt", 64'(redirect_cnt), 64'h1);
        tick();

        // Scenario 3: back-pressure with three requests
        out_ready = 1'b0;
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_4000);
        send(2'b00, 1'b0, 32'h0, 26'h000_0010, 32'h0);
        mode = 2'b01; taken = 1'b1; pc = 32'h0000_0100; label = 26'h000_0008;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s3_blocked", 64'(in_ready), 64'h0);
            check("s3_hold", 64'(target), 64'h0000_4000);
            tick();
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("s3_second", 64'(target), 64'h0000_0010);
        @(negedge clk);
        check("s3_third", 64'(target), 64'h0000_0108);
        tick();

        // Scenario 4: reserved mode and misaligned register target
        send(2'b11, 1'b1, 32'h0, 26'h0, 32'h0);
        wait_out(lat);
        check("s4_err", 64'(err), 64'h1);
        check("s4_target", 64'(target), 64'h0);
        check("s4_redirect", 64'(redirect), 64'h0);
        tick();
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_1002);
        wait_out(lat);
        check("s4_reg_target", 64'(target), 64'h0000_1002);
`ifdef BTU_ALIGN_CHECK_EN
        check("s4_align_err", 64'(err), 64'h1);
        check("s4_align_redirect", 64'(redirect), 64'h0);
`else
        check("s4_align_err", 64'(err), 64'h0);
        check("s4_align_redirect", 64'(redirect), 64'h1);
`endif
        tick();

        // Scenario 5: flush with both stages full, then flush during a transfer
        out_ready = 1'b0;
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0020);
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0024);
        flush = 1'b1; in_valid = 1'b1; rs_val = 32'h0000_0028;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("s5_flushed", 64'(out_valid), 64'h0);
        tick();
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0030);
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0034);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("s5_flush_xfer_valid", 64'(out_valid), 64'h0);
`ifdef BTU_ALIGN_CHECK_EN
        check("s5_flush_xfer_cnt", 64'(redirect_cnt), 64'h4);
`else
        check("s5_flush_xfer_cnt", 64'(redirect_cnt), 64'h5);
`endif
        tick();
        out_ready = 1'b0;
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0040);
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0044);
        #2 rst = 1'b0;
        #1;
        check("s5_rst_valid", 64'(out_valid), 64'h0);
        check("s5_rst_target", 64'(target), 64'h0);
        check("s5_rst_redirect", 64'(redirect), 64'h0);
        check("s5_rst_err", 64'(err), 64'h0);
        check("s5_rst_cnt", 64'(redirect_cnt), 64'h0);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("s5_ready_after_rst", 64'(in_ready), 64'h1);
        tick();

        // Scenario 6: counter saturation
        for (int i = 0; i < 16; i++) send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0100);
        repeat (4) @(negedge clk);
        check("s6_cnt16", 64'(redirect_cnt), 64'hF);
        tick();
        send(2'b10, 1'b1, 32'h0, 26'h0, 32'h0000_0104);
        repeat (4) @(negedge clk);
        check("s6_cnt17", 64'(redirect_cnt), 64'hF);
        tick();

        // Randomised traffic against the model, after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            taken     = 1'($urandom_range(0, 1));
            pc        = $urandom;
            label     = 26'($urandom);
            rs_val    = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
